// File: rtl/eth_pkg.sv
// Shared types, frame constants and CRC/checksum helpers for the Ethernet transmit path.
package eth_pkg;

    localparam int unsigned WORD_W       = 32;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned CNT_W        = 16;

    localparam int unsigned PREAMBLE_LEN = 8;
    localparam int unsigned MAC_HDR_LEN  = 14;
    localparam int unsigned IP_HDR_LEN   = 20;
    localparam int unsigned UDP_LEN      = 12;
    localparam int unsigned PAD_LEN      = 14;
    localparam int unsigned FCS_LEN      = 4;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_FLAGS_FRAG  = 16'h4000;
    localparam logic [15:0] IP_TOTAL_LEN   = 16'(IP_HDR_LEN + UDP_LEN);

    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        MAC_HDR,
        IP_HDR,
        UDP,
        PAD,
        FCS,
        IFG
    } state_t;

    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] checksum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ipv4_hdr_t;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] crc32_update(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Header checksum; the checksum field of the argument is treated as zero.
    function automatic logic [15:0] ipv4_checksum(input ipv4_hdr_t hdr);
        ipv4_hdr_t    h;
        logic [159:0] flat;
        logic [31:0]  sum;
        h          = hdr;
        h.checksum = '0;
        flat       = h;
        sum        = '0;
        for (int i = 0; i < 10; i++) begin
            sum = sum + {16'h0, flat[16*i +: 16]};
        end
        sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        sum = {16'h0, sum[15:0]} + {16'h0, sum[31:16]};
        return ~sum[15:0];
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// Packet-in handshake and MII-side byte stream of the transmit framer.
interface eth_tx_framer_if;
    import eth_pkg::*;

    logic [WORD_W-1:0] packet_in;
    logic              packet_valid;
    logic              in_ready;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_en;

    modport master (
        output packet_in,
        output packet_valid,
        input  in_ready,
        input  tx_data,
        input  tx_en
    );

    modport slave (
        input  packet_in,
        input  packet_valid,
        output in_ready,
        output tx_data,
        output tx_en
    );

endinterface

// File: rtl/crc32_byte.sv
// Combinational byte-wide CRC-32 step, shared by the transmit and receive paths.
module crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out_c
);

    assign crc_out_c = crc32_update(crc_in, data);

endmodule

// File: rtl/eth_tx_framer.sv
// Buffers one 3-word UDP packet and streams it out as a complete Ethernet II / IPv4 frame.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0200_0000_0001,
    parameter logic [31:0] SRC_IP     = 32'hC0A8_0001,
    parameter logic [31:0] DST_IP     = 32'hC0A8_0002,
    parameter int unsigned IFG_CYCLES = 12
) (
    input logic           clk,
    input logic           rst_n,
    eth_tx_framer_if.slave bus
);

    localparam int unsigned SEL_W = 160;
    localparam logic [8*MAC_HDR_LEN-1:0] MAC_HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE_IPV4};

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;

    logic [1:0]          wcnt;
    logic [8*UDP_LEN-1:0] udp_buf;
    logic [15:0]         ip_id;
    logic [15:0]         ip_cs;
    logic [31:0]         crc;
    logic [31:0]         crc_next_c;

    logic [7:0]          byte_c;
    logic                en_c;
    logic                accept_c;
    logic                last_word_c;

    logic [7:0]          tx_data_q;
    logic                tx_en_q;
    logic                in_ready_q;

    ipv4_hdr_t             ip_hdr_c;
    logic [8*IP_HDR_LEN-1:0] ip_flat_c;

    function automatic logic at_end(input logic [CNT_W-1:0] c, input int unsigned len);
        return c == CNT_W'(len - 1);
    endfunction

    // Byte idx (0 = most significant) of a right-aligned len-byte field.
    function automatic logic [7:0] byte_of(input logic [SEL_W-1:0] vec, input int unsigned len,
                                           input logic [CNT_W-1:0] idx);
        return 8'(vec >> (8 * (len - 1 - 32'(idx))));
    endfunction

    always_comb begin
        ip_hdr_c            = '0;
        ip_hdr_c.ver_ihl    = IP_VER_IHL;
        ip_hdr_c.tos        = 8'h00;
        ip_hdr_c.total_len  = IP_TOTAL_LEN;
        ip_hdr_c.id         = ip_id;
        ip_hdr_c.flags_frag = IP_FLAGS_FRAG;
        ip_hdr_c.ttl        = IP_TTL;
        ip_hdr_c.proto      = IP_PROTO_UDP;
        ip_hdr_c.checksum   = ip_cs;
        ip_hdr_c.src_ip     = SRC_IP;
        ip_hdr_c.dst_ip     = DST_IP;
    end

    assign ip_flat_c = ip_hdr_c;

    crc32_byte u_crc (
        .crc_in    (crc),
        .data      (byte_c),
        .crc_out_c (crc_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state and the byte to emit for the current state/offset.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CNT_W'(1);
        byte_c      = 8'h00;
        en_c        = 1'b0;
        accept_c    = 1'b0;
        last_word_c = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                accept_c = bus.packet_valid;
                if (bus.packet_valid && (wcnt == 2'd2)) begin
                    last_word_c = 1'b1;
                    state_next  = PREAMBLE;
                end
            end
            PREAMBLE: begin
                en_c   = 1'b1;
                byte_c = at_end(cnt, PREAMBLE_LEN) ? 8'hD5 : 8'h55;
                if (at_end(cnt, PREAMBLE_LEN)) begin
                    state_next = MAC_HDR;
                    cnt_next   = '0;
                end
            end
            MAC_HDR: begin
                en_c   = 1'b1;
                byte_c = byte_of(SEL_W'(MAC_HDR_BYTES), MAC_HDR_LEN, cnt);
                if (at_end(cnt, MAC_HDR_LEN)) begin
                    state_next = IP_HDR;
                    cnt_next   = '0;
                end
            end
            IP_HDR: begin
                en_c   = 1'b1;
                byte_c = byte_of(SEL_W'(ip_flat_c), IP_HDR_LEN, cnt);
                if (at_end(cnt, IP_HDR_LEN)) begin
                    state_next = UDP;
                    cnt_next   = '0;
                end
            end
            UDP: begin
                en_c   = 1'b1;
                byte_c = byte_of(SEL_W'(udp_buf), UDP_LEN, cnt);
                if (at_end(cnt, UDP_LEN)) begin
                    state_next = PAD;
                    cnt_next   = '0;
                end
            end
            PAD: begin
                en_c = 1'b1;
                if (at_end(cnt, PAD_LEN)) begin
                    state_next = FCS;
                    cnt_next   = '0;
                end
            end
            FCS: begin
                en_c   = 1'b1;
                byte_c = 8'(~crc >> (8 * 32'(cnt)));
                if (at_end(cnt, FCS_LEN)) begin
                    state_next = IFG;
                    cnt_next   = '0;
                end
            end
            IFG: begin
                if (at_end(cnt, IFG_CYCLES)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Packet buffer, header state, running CRC and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            udp_buf    <= '0;
            wcnt       <= '0;
            ip_id      <= '0;
            ip_cs      <= '0;
            crc        <= CRC32_INIT;
            tx_data_q  <= '0;
            tx_en_q    <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            tx_data_q  <= byte_c;
            tx_en_q    <= en_c;
            in_ready_q <= (state_next == IDLE);
            if (accept_c) begin
                udp_buf <= {udp_buf[8*UDP_LEN-WORD_W-1:0], bus.packet_in};
                wcnt    <= last_word_c ? 2'd0 : wcnt + 2'd1;
            end
            if (last_word_c) begin
                ip_cs <= ipv4_checksum(ip_hdr_c);
            end
            case (state)
                PREAMBLE:                  crc <= CRC32_INIT;
                MAC_HDR, IP_HDR, UDP, PAD: crc <= crc_next_c;
                default:                   crc <= crc;
            endcase
            if ((state == FCS) && at_end(cnt, FCS_LEN)) begin
                ip_id <= ip_id + 16'd1;
            end
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_en    = tx_en_q;
    assign bus.in_ready = in_ready_q;

endmodule
